sao_lcu_sched: RTL and testbench
================================

Name: sao_lcu_sched

Overview:
- LCU-level scheduler that sequences a full 128x128 frame through the SAO engine.
- Walks LCUs in raster order and drives per-LCU SAO parameters from an internal parameter table.
- Reads source pixels from the frame buffer and streams them to the engine as in_en/din, honouring the engine's busy back-pressure.
- Pulses done once the engine raises finish after the last LCU.

Parameters:
- FRAME_W, 128, frame width and height in pixels; fixed square frame, must be 128.
- NUM_PARAM, 64, parameter table depth, one entry per LCU of the worst-case 8x8 grid.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a frame when in IDLE
- cfg_lcu_size  in  2  0=16x16, 1=32x32, 2/3=64x64; sampled on start
- prm_we  in  1  parameter table write strobe
- prm_addr  in  6  table index = lcu_y*NLCU + lcu_x
- prm_wdata  in  24  {sao_type[23:22], band_pos[21:17], eo_class[16], offset[15:0]}
- pix_addr  out  14  frame buffer read address {row[6:0], col[6:0]}
- pix_re  out  1  frame buffer read enable
- pix_rdata  in  8  read data, valid exactly 1 cycle after pix_re
- in_en  out  1  pixel valid to engine
- din  out  8  pixel to engine
- sao_type, sao_band_pos, sao_eo_class, sao_offset  out  2/5/1/16  current LCU parameters
- lcu_x, lcu_y  out  3/3  current LCU coordinates
- lcu_size  out  2  latched cfg_lcu_size
- busy  in  1  engine back-pressure
- finish  in  1  engine frame-complete flag
- sched_busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: all outputs 0, FSM in IDLE, table contents 0.
- Derived values:
  - S = 16<<lcu_size (64 for size 2 or 3).
  - NLCU = 128/S, i.e. 8, 4 or 2.
  - px, py: 6-bit intra-LCU counters.
  - pix_addr row = lcu_y*S+py, col = lcu_x*S+px, computed in 7 bits.
- Parameter table:
  - prm_we is honoured only in IDLE; writes in any other state are dropped.
  - Entries for unused indices (index >= NLCU*NLCU) are never read.
- FSM states:
  - IDLE: on start, latch cfg_lcu_size, clear lcu_x/lcu_y, go to LOAD. start while sched_busy=1 is ignored.
  - LOAD (1 cycle): read the table entry for (lcu_x, lcu_y) and register it onto the sao_* outputs. These hold stable for the whole LCU. Go to STREAM.
  - STREAM:
    - Each cycle with busy=0 and the skid register empty: assert pix_re, advance px, then py, in raster order.
    - Data returns the next cycle and drives in_en=1/din.
    - If busy=1 when data returns, the beat is held in a one-entry skid register and presented on the first cycle with busy=0. No new read issues while the skid register is full or busy=1.
    - After the last address (px=py=S-1) is issued, go to GAP.
  - GAP: wait until the final beat is delivered and busy=0, keep in_en=0 for at least 1 full cycle, then:
    - not last LCU: advance lcu_x, wrapping to 0 and incrementing lcu_y, then go to LOAD;
    - last LCU: go to WAITFIN.
  - WAITFIN: when finish=1, pulse done for 1 cycle, go to IDLE.
- Ordering and counts:
  - in_en never asserts outside STREAM/GAP.
  - Exactly S*S beats are delivered per LCU, in raster order, none dropped or duplicated.
- Latency: pix_re to in_en is 1 cycle with no stall; first pix_re occurs 2 cycles after start.
- Simultaneous events:
  - busy rising in the same cycle as a data return: the beat goes to the skid register, not to din.
  - finish arriving before WAITFIN is ignored.
- Reset mid-frame: immediately returns to IDLE, all outputs 0. The table is cleared and must be reloaded.

Optional Feature:
- SAO_SCHED_PERF_EN defined:
  - adds output stall_cnt[15:0], counting STREAM/GAP cycles where busy=1.
  - clears on accepted start and saturates at 16'hFFFF.
  - holds its value after done.
- SAO_SCHED_PERF_EN not defined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- lcu_size=2, busy tied 0, frame ramp pix=col^row:
  - 4 LCUs of 4096 beats each, in_en gaps >=1 cycle between LCUs;
  - first LCU din sequence 0,1,2,...;
  - done one cycle after finish.
- lcu_size=0, table entry k = {2'd1, k[4:0], 1'b0, 16'h1F3C}:
  - 64 LCUs; for LCU (x=3,y=5) the sao_band_pos output is 5'd11;
  - pix_addr of its first beat is {7'd80, 7'd48}.
- lcu_size=1, busy pulsed high for 3 cycles at beat 100 and on alternate cycles for beats 500-600:
  - delivered din sequence is identical to the busy=0 run;
  - 1024 beats per LCU.
- prm_we during STREAM to index 0 with 24'hFFFFFF:
  - the table is unchanged, verified on the next frame.
- reset asserted at beat 300 of LCU 2:
  - all outputs 0 within the same cycle, state IDLE;
  - a following start runs a complete frame.
- With SAO_SCHED_PERF_EN: 3-cycle busy stall x 4 occurrences -> stall_cnt=12 at done.

Source files
------------

// File: rtl/sao_lcu_sched.sv
// sao_lcu_sched: LCU-level scheduler that streams one 128x128 frame through the SAO engine.
//
// Walks LCUs in raster order. For each LCU it loads the SAO parameters from an internal
// table, then reads the LCU's pixels from the frame buffer in raster order and forwards them
// to the engine. A one-entry skid register absorbs the beat in flight when the engine stalls.
// After the last LCU it waits for the engine's finish flag and then pulses done.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start                 one-cycle frame start (ignored while sched_busy)
//   cfg_lcu_size          0=16x16, 1=32x32, 2/3=64x64, sampled on start
//   prm_we/addr/wdata     parameter table write port, honoured only while idle
//   pix_addr/re/rdata     frame buffer read port, rdata valid one cycle after re
//   in_en, din            pixel stream to the engine
//   sao_*                 parameters of the current LCU
//   lcu_x, lcu_y          current LCU coordinates
//   lcu_size              latched cfg_lcu_size
//   busy, finish          engine back-pressure and frame-complete flag
//   sched_busy, done      frame in progress, one-cycle frame-end pulse
//
// Optional feature: define SAO_SCHED_PERF_EN to add stall_cnt[15:0], a saturating count of
// STREAM/GAP cycles with busy=1, cleared on an accepted start.

module sao_lcu_sched #(
    parameter int unsigned FRAME_W   = 128,
    parameter int unsigned NUM_PARAM = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cfg_lcu_size,
    input  logic        prm_we,
    input  logic [5:0]  prm_addr,
    input  logic [23:0] prm_wdata,
    output logic [13:0] pix_addr,
    output logic        pix_re,
    input  logic [7:0]  pix_rdata,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  sao_type,
    output logic [4:0]  sao_band_pos,
    output logic        sao_eo_class,
    output logic [15:0] sao_offset,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  lcu_size,
    input  logic        busy,
    input  logic        finish,
    output logic        sched_busy,
    output logic        done
`ifdef SAO_SCHED_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int unsigned CoordW = $clog2(FRAME_W);

    typedef enum logic [2:0] {StIdle, StLoad, StStream, StGap, StWaitFin} state_e;

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  lx_q, lx_d, ly_q, ly_d;
    logic [5:0]  px_q, px_d, py_q, py_d;
    logic [23:0] prm_q, prm_d;
    logic        rd_pend_q, rd_pend_d;
    logic        skid_full_q, skid_full_d;
    logic [7:0]  skid_q, skid_d;
    logic        done_q, done_d;
    logic [23:0] tbl_q [NUM_PARAM];

    // Geometry derived from the latched LCU size
    logic [5:0]        s_m1;
    logic [2:0]        n_m1;
    logic [2:0]        lg_s;
    logic [5:0]        prm_idx;
    logic [CoordW-1:0] row, col;

    always_comb begin
        unique case (size_q)
            2'd0: begin s_m1 = 6'd15; n_m1 = 3'd7; lg_s = 3'd4; end
            2'd1: begin s_m1 = 6'd31; n_m1 = 3'd3; lg_s = 3'd5; end
            default: begin s_m1 = 6'd63; n_m1 = 3'd1; lg_s = 3'd6; end
        endcase
    end

    // Table index lcu_y*NLCU + lcu_x, with NLCU a power of two
    always_comb begin
        unique case (size_q)
            2'd0:    prm_idx = {ly_q, lx_q};
            2'd1:    prm_idx = {2'b00, ly_q[1:0], lx_q[1:0]};
            default: prm_idx = {4'b0000, ly_q[0], lx_q[0]};
        endcase
    end

    assign row = ({4'b0000, ly_q} << lg_s) + {1'b0, py_q};
    assign col = ({4'b0000, lx_q} << lg_s) + {1'b0, px_q};

    logic issue, last_pix, last_lcu;
    logic deliver_rd, deliver_skid, to_skid, drained;

    // A read issues only when the return path is guaranteed a free slot
    assign issue        = (state_q == StStream) && !busy && !skid_full_q;
    assign last_pix     = (px_q == s_m1) && (py_q == s_m1);
    assign last_lcu     = (lx_q == n_m1) && (ly_q == n_m1);
    assign deliver_rd   = rd_pend_q && !busy;
    assign to_skid      = rd_pend_q && busy;
    assign deliver_skid = skid_full_q && !busy;
    assign drained      = !rd_pend_q && !skid_full_q && !busy;

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        lx_d        = lx_q;
        ly_d        = ly_q;
        px_d        = px_q;
        py_d        = py_q;
        prm_d       = prm_q;
        rd_pend_d   = issue;
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        done_d      = 1'b0;

        if (to_skid) begin
            skid_full_d = 1'b1;
            skid_d      = pix_rdata;
        end else if (deliver_skid) begin
            skid_full_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    size_d  = cfg_lcu_size;
                    lx_d    = 3'd0;
                    ly_d    = 3'd0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                prm_d   = tbl_q[prm_idx];
                px_d    = 6'd0;
                py_d    = 6'd0;
                state_d = StStream;
            end
            StStream: begin
                if (issue) begin
                    if (px_q == s_m1) begin
                        px_d = 6'd0;
                        py_d = py_q + 6'd1;
                    end else begin
                        px_d = px_q + 6'd1;
                    end
                    if (last_pix) begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                // The qualifying cycle itself has in_en=0, which provides the idle gap
                if (drained) begin
                    if (last_lcu) begin
                        state_d = StWaitFin;
                    end else begin
                        if (lx_q == n_m1) begin
                            lx_d = 3'd0;
                            ly_d = ly_q + 3'd1;
                        end else begin
                            lx_d = lx_q + 3'd1;
                        end
                        state_d = StLoad;
                    end
                end
            end
            StWaitFin: begin
                if (finish) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            size_q      <= 2'd0;
            lx_q        <= 3'd0;
            ly_q        <= 3'd0;
            px_q        <= 6'd0;
            py_q        <= 6'd0;
            prm_q       <= 24'd0;
            rd_pend_q   <= 1'b0;
            skid_full_q <= 1'b0;
            skid_q      <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            lx_q        <= lx_d;
            ly_q        <= ly_d;
            px_q        <= px_d;
            py_q        <= py_d;
            prm_q       <= prm_d;
            rd_pend_q   <= rd_pend_d;
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
            done_q      <= done_d;
        end
    end

    // Parameter table; cleared by reset, writable only while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PARAM; i++) begin
                tbl_q[i] <= 24'd0;
            end
        end else if ((state_q == StIdle) && prm_we) begin
            tbl_q[prm_addr] <= prm_wdata;
        end
    end

`ifdef SAO_SCHED_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 16'd0;
        end else if ((state_q == StIdle) && start) begin
            stall_q <= 16'd0;
        end else if (((state_q == StStream) || (state_q == StGap)) && busy &&
                     (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign pix_addr     = {row, col};
    assign pix_re       = issue;
    assign in_en        = deliver_rd || deliver_skid;
    assign din          = deliver_skid ? skid_q : (deliver_rd ? pix_rdata : 8'd0);
    assign sao_type     = prm_q[23:22];
    assign sao_band_pos = prm_q[21:17];
    assign sao_eo_class = prm_q[16];
    assign sao_offset   = prm_q[15:0];
    assign lcu_x        = lx_q;
    assign lcu_y        = ly_q;
    assign lcu_size     = size_q;
    assign sched_busy   = (state_q != StIdle);
    assign done         = done_q;

endmodule

// File: tb/tb_sao_lcu_sched.sv
// Testbench for sao_lcu_sched: frame-buffer model, engine stub and a beat/address scoreboard.

module tb_sao_lcu_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cfg_lcu_size = 2'd0;
    logic        prm_we = 1'b0;
    logic [5:0]  prm_addr = 6'd0;
    logic [23:0] prm_wdata = 24'd0;
    logic [13:0] pix_addr;
    logic        pix_re;
    logic [7:0]  pix_rdata = 8'd0;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  sao_type;
    logic [4:0]  sao_band_pos;
    logic        sao_eo_class;
    logic [15:0] sao_offset;
    logic [2:0]  lcu_x, lcu_y;
    logic [1:0]  lcu_size;
    logic        busy = 1'b0;
    logic        finish = 1'b0;
    logic        sched_busy;
    logic        done;
`ifdef SAO_SCHED_PERF_EN
    logic [15:0] stall_cnt;
`endif

    sao_lcu_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_lcu_size (cfg_lcu_size),
        .prm_we       (prm_we),
        .prm_addr     (prm_addr),
        .prm_wdata    (prm_wdata),
        .pix_addr     (pix_addr),
        .pix_re       (pix_re),
        .pix_rdata    (pix_rdata),
        .in_en        (in_en),
        .din          (din),
        .sao_type     (sao_type),
        .sao_band_pos (sao_band_pos),
        .sao_eo_class (sao_eo_class),
        .sao_offset   (sao_offset),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size     (lcu_size),
        .busy         (busy),
        .finish       (finish),
        .sched_busy   (sched_busy),
        .done         (done)
`ifdef SAO_SCHED_PERF_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Frame buffer: pixel = row ^ col, one-cycle read latency
    always @(posedge clk) begin
        if (pix_re) pix_rdata <= pix_addr[6:0] ^ pix_addr[13:7];
    end

    typedef struct packed {
        logic [7:0]  pix;
        logic [2:0]  x;
        logic [2:0]  y;
        logic [23:0] prm;
    } beat_t;

    beat_t       exp_q[$];
    logic [13:0] addr_q[$];
    logic [23:0] tbl_m [64];

    int n_total = 0;
    int n_pass = 0;
    int lb = 0;
    int cur_lcu = -1;
    int beats_total = 0;
    int done_cnt = 0;
    logic prev_in_en = 1'b0;

    bit          watch_en = 1'b0;
    bit          watched = 1'b0;
    logic [2:0]  wx = 3'd0, wy = 3'd0;
    logic [13:0] watched_addr = 14'd0;
    logic [4:0]  watched_band = 5'd0;
    logic [23:0] first_prm = 24'd0;

    // Monitor: checks every issued address and every delivered beat against the scoreboard
    always @(negedge clk) begin
        beat_t b;
        logic [13:0] a;
        int lid;
        if (reset) begin
            if (pix_re) begin
                n_total++;
                if (addr_q.size() == 0) begin
                    $display("FAIL pix_addr_order: got unexpected read %0h, want none", pix_addr);
                end else begin
                    a = addr_q.pop_front();
                    if (pix_addr !== a)
                        $display("FAIL pix_addr_order: got %0h, want %0h", pix_addr, a);
                    else n_pass++;
                end
                if (watch_en && !watched && lcu_x == wx && lcu_y == wy) begin
                    watched      = 1'b1;
                    watched_addr = pix_addr;
                    watched_band = sao_band_pos;
                end
            end
            if (in_en) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat: got unexpected beat din=%0h, want none", din);
                end else begin
                    b = exp_q.pop_front();
                    if ({din, lcu_x, lcu_y, sao_type, sao_band_pos, sao_eo_class, sao_offset}
                        !== {b.pix, b.x, b.y, b.prm})
                        $display("FAIL beat: got din=%0h x=%0d y=%0d prm=%0h, want din=%0h x=%0d y=%0d prm=%0h",
                                 din, lcu_x, lcu_y,
                                 {sao_type, sao_band_pos, sao_eo_class, sao_offset},
                                 b.pix, b.x, b.y, b.prm);
                    else n_pass++;
                    lid = int'(b.y) * 8 + int'(b.x);
                    if (lid != cur_lcu) begin
                        if (cur_lcu != -1) begin
                            n_total++;
                            if (prev_in_en !== 1'b0)
                                $display("FAIL lcu_gap: got in_en=%0b before LCU %0d, want 0",
                                         prev_in_en, lid);
                            else n_pass++;
                        end
                        cur_lcu = lid;
                        lb = 1;
                    end else begin
                        lb++;
                    end
                    beats_total++;
                end
            end
            if (done) done_cnt++;
        end
        prev_in_en = in_en;
    end

    task automatic push_frame(input int size);
        int s, n;
        beat_t b;
        s = (size >= 2) ? 64 : (16 << size);
        n = 128 / s;
        for (int ly = 0; ly < n; ly++)
            for (int lx = 0; lx < n; lx++)
                for (int py = 0; py < s; py++)
                    for (int px = 0; px < s; px++) begin
                        int row, col;
                        row   = ly * s + py;
                        col   = lx * s + px;
                        b.pix = 8'(row ^ col);
                        b.x   = 3'(lx);
                        b.y   = 3'(ly);
                        b.prm = tbl_m[ly * n + lx];
                        exp_q.push_back(b);
                        addr_q.push_back({7'(row), 7'(col)});
                    end
    endtask

    // mode 0: pseudo-varied entries; mode 1: {2'd1, k[4:0], 1'b0, 16'h1F3C}
    task automatic load_table(input int mode);
        for (int k = 0; k < 64; k++) begin
            logic [23:0] v;
            logic [7:0]  kk;
            kk = 8'(k);
            if (mode == 0) v = 24'hA50000 ^ 24'(k * 24'h031337);
            else v = {2'd1, kk[4:0], 1'b0, 16'h1F3C};
            tbl_m[k]  = v;
            prm_we    = 1'b1;
            prm_addr  = 6'(k);
            prm_wdata = v;
            @(posedge clk); #1;
        end
        prm_we = 1'b0;
    endtask

    // busy_mode 0: never busy; 1: 3-cycle stall at beat 100 and alternate busy over beats
    // 500..600 of every LCU; 2: 3-cycle stall at beat 100 of the first four LCUs only
    task automatic run_frame(input int size, input int busy_mode, input bit early_fin,
                             input bit prm_poke, input int abort_beat, output bit aborted);
        int cyc, trig, stall_left;
        aborted = 1'b0;
        push_frame(size);
        cur_lcu = -1; lb = 0; beats_total = 0; done_cnt = 0;
        trig = -1; stall_left = 0; watched = 1'b0;
        cfg_lcu_size = 2'(size);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_total++;
        if ({sched_busy, pix_re} !== 2'b10)
            $display("FAIL load_cycle: got sched_busy,pix_re=%b, want 10", {sched_busy, pix_re});
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (pix_re !== 1'b1) $display("FAIL first_read_latency: got pix_re=%b, want 1", pix_re);
        else n_pass++;
        first_prm = {sao_type, sao_band_pos, sao_eo_class, sao_offset};
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            if (abort_beat >= 0 && beats_total >= abort_beat) begin
                aborted = 1'b1;
                break;
            end
            if (stall_left > 0) begin
                busy = 1'b1;
                stall_left--;
            end else if (busy_mode != 0 && lb == 100 && trig != cur_lcu &&
                         (busy_mode == 1 || cur_lcu < 4)) begin
                trig = cur_lcu;
                busy = 1'b1;
                stall_left = 2;
            end else if (busy_mode == 1 && lb >= 500 && lb <= 600) begin
                busy = (cyc % 2 == 1);
            end else begin
                busy = 1'b0;
            end
            prm_we    = prm_poke && (cyc == 50);
            prm_addr  = 6'd0;
            prm_wdata = 24'hFFFFFF;
            finish    = early_fin && (cyc == 200);
        end
        busy = 1'b0; prm_we = 1'b0; finish = 1'b0;
        if (aborted) return;
        n_total++;
        if (cyc >= 40000) $display("FAIL frame_timeout: got %0d beats left, want 0", exp_q.size());
        else n_pass++;
        n_total++;
        if (addr_q.size() !== 0)
            $display("FAIL read_count: got %0d reads missing, want 0", addr_q.size());
        else n_pass++;
        repeat (4) begin @(posedge clk); #1; end
        n_total++;
        if (done_cnt !== 0) $display("FAIL no_early_done: got %0d done pulses, want 0", done_cnt);
        else n_pass++;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        n_total++;
        if ({done, sched_busy} !== 2'b10)
            $display("FAIL done_pulse: got done,sched_busy=%b, want 10", {done, sched_busy});
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (done !== 1'b0) $display("FAIL done_width: got done=%b, want 0", done);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({pix_addr, pix_re, in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
             lcu_x, lcu_y, lcu_size, sched_busy, done} !== 58'd0)
            $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_size64_frame();
        bit ab;
        load_table(0);
        run_frame(2, 0, 1'b1, 1'b0, -1, ab);
        n_total++;
        if (first_prm !== tbl_m[0])
            $display("FAIL lcu0_params: got %0h, want %0h", first_prm, tbl_m[0]);
        else n_pass++;
    endtask

    task automatic test_size16_params();
        bit ab;
        load_table(1);
        watch_en = 1'b1; wx = 3'd3; wy = 3'd5;
        run_frame(0, 0, 1'b0, 1'b1, -1, ab);
        watch_en = 1'b0;
        n_total++;
        if ({watched, watched_band} !== {1'b1, 5'd11})
            $display("FAIL lcu35_band_pos: got seen=%b band=%0d, want seen=1 band=11",
                     watched, watched_band);
        else n_pass++;
        n_total++;
        if (watched_addr !== {7'd80, 7'd48})
            $display("FAIL lcu35_first_addr: got %0h, want %0h", watched_addr, {7'd80, 7'd48});
        else n_pass++;
    endtask

    task automatic test_busy_size32();
        bit ab;
        run_frame(1, 1, 1'b0, 1'b0, -1, ab);
        // Index 0 was written during streaming in the previous frame; it must be unchanged
        n_total++;
        if (first_prm !== {2'd1, 5'd0, 1'b0, 16'h1F3C})
            $display("FAIL table_protect: got %0h, want %0h", first_prm,
                     {2'd1, 5'd0, 1'b0, 16'h1F3C});
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit ab;
        run_frame(1, 0, 1'b0, 1'b0, 2 * 1024 + 300, ab);
        n_total++;
        if (ab !== 1'b1) $display("FAIL abort_point: got reached=%b, want 1", ab);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if ({pix_addr, pix_re, in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
             lcu_x, lcu_y, lcu_size, sched_busy, done} !== 58'd0)
            $display("FAIL midframe_reset_outputs: got nonzero outputs, want all 0");
        else n_pass++;
        exp_q.delete();
        addr_q.delete();
        for (int k = 0; k < 64; k++) tbl_m[k] = 24'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame_after_reset();
        bit ab;
        load_table(1);
        run_frame(0, 2, 1'b0, 1'b0, -1, ab);
`ifdef SAO_SCHED_PERF_EN
        n_total++;
        if (stall_cnt !== 16'd12) $display("FAIL stall_cnt: got %0d, want 12", stall_cnt);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_size64_frame();
        test_size16_params();
        test_busy_size32();
        test_reset_mid_frame();
        test_frame_after_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
